fifo_level: RTL and testbench
=============================

# fifo_level

Synchronous single-clock FIFO: the parametrised successor to the existing `fifo`, which has fixed depth handling and full/empty flags only. This block adds:
- a fill-level count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a synchronous flush;
- a selectable read mode, either standard registered read or first-word-fall-through (FWFT).

It sits between byte producers and consumers such as the UART TX path, where back-pressure needs early warning.

## Interface
- `Width`, 8: data word width in bits (≥1).
- `Depth`, 16: number of entries. Must be a power of 2 and ≥2.
- `AlmostFull`, 14: `o_almost_full` asserts when count ≥ `AlmostFull`. Legal range 1..`Depth`.
- `AlmostEmpty`, 2: `o_almost_empty` asserts when count ≤ `AlmostEmpty`. Legal range 0..`Depth`-1.
- `Mode`, 0: 0 selects standard (STD) mode; 1 selects FWFT mode.

Ports:
- `i_clk`, in, 1: the single clock. All logic is on the rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_clr`, in, 1: synchronous flush.
- `i_wr`, in, 1: write request.
- `i_data`, in, `Width`: write data.
- `i_rd`, in, 1: read request. In FWFT mode it acts as the acknowledge of the head word.
- `o_data`, out, `Width`: read data.
- `o_valid`, out, 1: `o_data` holds a valid word.
- `o_full`, out, 1: FIFO full.
- `o_empty`, out, 1: FIFO empty.
- `o_almost_full`, out, 1: count ≥ `AlmostFull`.
- `o_almost_empty`, out, 1: count ≤ `AlmostEmpty`.
- `o_count`, out, $clog2(`Depth`)+1: number of stored words, 0..`Depth`.
- `o_overflow`, out, 1: sticky; set by a write attempted while full.
- `o_underflow`, out, 1: sticky; set by a read attempted while empty.

## Operation
- Write is accepted iff `i_wr` && !`o_full`. Read is accepted iff `i_rd` && !`o_empty`.
- Flags are evaluated on the registered state, before this cycle's update.
- Simultaneous write and read:
  - Both accepted: count is unchanged and both pointers advance.
  - When empty: the write is accepted, the read is rejected, and `o_underflow` is set.
  - When full: the read is accepted, the write is rejected, and `o_overflow` is set.
- Pointers are $clog2(`Depth`) bits wide and wrap naturally. Full and empty are derived from the count register, not from pointer compare.
- Count update: count += wr_acc − rd_acc. It never exceeds `Depth` and never goes below 0.
- `o_full`, `o_empty`, `o_almost_full`, `o_almost_empty` and `o_count` are all registered. Each is consistent with the post-update count.
- STD mode:
  - An accepted read registers mem[rd_ptr] into `o_data`.
  - `o_valid` pulses for 1 cycle.
  - `o_data` holds its value until the next accepted read.
- FWFT mode:
  - `o_data` always presents the head word.
  - `o_valid` = !`o_empty`.
  - An accepted `i_rd` consumes the head; the next word, if any, appears the following cycle.
- `i_clr`:
  - Resets pointers, count and `o_valid`, sets the flags to their empty state, and clears both sticky bits.
  - It overrides `i_wr` and `i_rd` in the same cycle: neither is accepted and no sticky bit is set.
  - Memory contents are not cleared.
- Sticky bits stay set until `i_clr` or `i_rst`.

## Timing
- Reset values on `i_rst` are asynchronous and take effect immediately:
  - pointers 0, `o_count` 0;
  - `o_empty` 1, `o_almost_empty` 1;
  - `o_full` 0, `o_almost_full` 0;
  - `o_data` 0, `o_valid` 0;
  - `o_overflow` 0, `o_underflow` 0.
- Storage is not reset.
- Write to an empty FIFO: `o_empty` falls and `o_count` reaches 1 on the next edge.
  - In FWFT mode the word is on `o_data` with `o_valid`=1 in that same cycle, i.e. 1-cycle write-to-read latency.
- STD read: `o_data` and the `o_valid` pulse appear 1 cycle after the `i_rd` edge.
- Back-to-back operation: one write and/or one read per cycle is sustained indefinitely. There are no bubbles.
- Reset asserted mid-operation drops all state within the same cycle. An accept in progress is discarded.
- The first accept after reset deassertion can occur on the first rising edge with `i_rst`=0.

## Structure
- Shared package/header `fifo_pkg` holds:
  - `FIFO_MODE_STD`=0 and `FIFO_MODE_FWFT`=1;
  - a `clog2` helper for pointer and count widths.
- Sub-module `fifo_ram`: `Depth`×`Width` register array with a synchronous write port and an asynchronous read port at `rd_addr`.
- The parent contains pointers, count, flags, sticky logic, and mode-dependent output registering.
- Parameter legality is checked at elaboration. An illegal `Depth`, `AlmostFull` or `AlmostEmpty` is a fatal error.

## Test plan
- **Reset/fill/drain:** `Depth`=4, STD mode; write 0xA1..0xA4, then read 4 times.
  - `o_count` steps 1→4; `o_full`=1 after the 4th write.
  - Reads return A1..A4 in order, each with an `o_valid` pulse.
  - `o_empty`=1 at the end.
- **Overflow/underflow:** `Depth`=4.
  - A 5th write while full is dropped, `o_overflow`=1, and the data stays A1..A4.
  - A read while empty gives `o_underflow`=1 with `o_count` still 0.
  - `i_clr` clears both sticky bits.
- **Simultaneous ops:**
  - Write and read together at count 2: count stays 2, and the data order is preserved across pointer wrap (16 cycles on `Depth`=4).
  - Both together when empty: the write is taken, count becomes 1, underflow is set.
  - Both together when full: the read is taken, count becomes 3, overflow is set.
- **Thresholds:** `Depth`=16, `AlmostFull`=14, `AlmostEmpty`=2.
  - `o_almost_empty` deasserts at count 3.
  - `o_almost_full` asserts at count 14 and deasserts on a drain to 13.
- **FWFT:** `Mode`=1.
  - Write 0x55 to empty: on the next cycle `o_data`=0x55, `o_valid`=1.
  - Write 0x66, then assert `i_rd`: the cycle after, `o_data`=0x66.
  - A further `i_rd` gives `o_valid`=0.
- **Async reset mid-stream:** at count 3, pulse `i_rst` between clock edges.
  - Outputs take their reset values immediately.
  - A subsequent write of 0x77 is read back first.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode encodings and width helper shared by the FIFO blocks
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: Depth x Width register array, sync write, async read
// i_clk clock; i_we/i_wr_addr/i_wr_data write port; i_rd_addr/o_rd_data read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [clog2(Depth)-1:0]   i_wr_addr,
  input  logic [Width-1:0]          i_wr_data,
  input  logic [clog2(Depth)-1:0]   i_rd_addr,
  output logic [Width-1:0]          o_rd_data
);
  logic [Width-1:0] mem [Depth];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_wr_addr] <= i_wr_data;
  assign o_rd_data = mem[i_rd_addr];
endmodule

// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with fill level, thresholds, sticky errors, flush, STD/FWFT read
// i_clk/i_rst clock and async reset; i_clr flush; i_wr/i_data write; i_rd read (FWFT: head ack)
// o_data/o_valid read data; o_full/o_empty/o_almost_full/o_almost_empty/o_count level status
// o_overflow/o_underflow sticky error flags
module fifo_level
  import fifo_pkg::*;
#(
  parameter int Width       = 8,
  parameter int Depth       = 16,
  parameter int AlmostFull  = 14,
  parameter int AlmostEmpty = 2,
  parameter int Mode        = FIFO_MODE_STD
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clr,
  input  logic                      i_wr,
  input  logic [Width-1:0]          i_data,
  input  logic                      i_rd,
  output logic [Width-1:0]          o_data,
  output logic                      o_valid,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_almost_full,
  output logic                      o_almost_empty,
  output logic [clog2(Depth):0]     o_count,
  output logic                      o_overflow,
  output logic                      o_underflow
);
  localparam int AW = clog2(Depth);
  localparam int CW = AW + 1;
  if (Width < 1) begin : g_bad_width
    $fatal(1, "fifo_level: Width must be >= 1");
  end
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_level: Depth must be a power of 2 and >= 2");
  end
  if (AlmostFull < 1 || AlmostFull > Depth) begin : g_bad_af
    $fatal(1, "fifo_level: AlmostFull must be in 1..Depth");
  end
  if (AlmostEmpty < 0 || AlmostEmpty > Depth - 1) begin : g_bad_ae
    $fatal(1, "fifo_level: AlmostEmpty must be in 0..Depth-1");
  end
  if (Mode != FIFO_MODE_STD && Mode != FIFO_MODE_FWFT) begin : g_bad_mode
    $fatal(1, "fifo_level: Mode must be 0 (STD) or 1 (FWFT)");
  end
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [Width-1:0] ram_q, data_q;
  logic             valid_q, wr_acc, rd_acc;
  logic [CW-1:0]    cnt_nxt;
  // flush wins over both requests so nothing is stored or consumed in a clr cycle
  assign wr_acc  = i_wr && !o_full && !i_clr;
  assign rd_acc  = i_rd && !o_empty && !i_clr;
  assign cnt_nxt = o_count + CW'(wr_acc) - CW'(rd_acc);
  fifo_ram #(.Width(Width), .Depth(Depth)) u_ram (
    .i_clk     (i_clk),
    .i_we      (wr_acc),
    .i_wr_addr (wr_ptr),
    .i_wr_data (i_data),
    .i_rd_addr (rd_ptr),
    .o_rd_data (ram_q)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
      data_q         <= '0;
      valid_q        <= 1'b0;
    end else if (i_clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_count        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
      valid_q        <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr + AW'(wr_acc);
      rd_ptr         <= rd_ptr + AW'(rd_acc);
      o_count        <= cnt_nxt;
      o_full         <= cnt_nxt == CW'(Depth);
      o_empty        <= cnt_nxt == '0;
      o_almost_full  <= cnt_nxt >= CW'(AlmostFull);
      o_almost_empty <= cnt_nxt <= CW'(AlmostEmpty);
      o_overflow     <= o_overflow | (i_wr & o_full);
      o_underflow    <= o_underflow | (i_rd & o_empty);
      if (rd_acc) data_q <= ram_q;
      valid_q        <= rd_acc;
    end
  // FWFT shows the head straight from the array; forced to 0 while empty so the
  // output never exposes stale or uninitialised storage
  assign o_data  = (Mode == FIFO_MODE_FWFT) ? (o_empty ? '0 : ram_q) : data_q;
  assign o_valid = (Mode == FIFO_MODE_FWFT) ? !o_empty : valid_q;
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed checks of fifo_level in STD (Depth 4 and 16) and FWFT (Depth 4)
module tb_fifo_level;
  logic clk, rst, clr, wr, rd;
  logic [7:0] data;
  logic [7:0] a_data, b_data, f_data;
  logic a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] a_count, f_count;
  logic [4:0] b_count;
  int n_cmp, n_bad;
  fifo_level #(.Width(8), .Depth(4), .AlmostFull(3), .AlmostEmpty(1), .Mode(0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr(wr), .i_data(data), .i_rd(rd),
    .o_data(a_data), .o_valid(a_valid), .o_full(a_full), .o_empty(a_empty),
    .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_count),
    .o_overflow(a_ovf), .o_underflow(a_udf)
  );
  fifo_level #(.Width(8), .Depth(16), .AlmostFull(14), .AlmostEmpty(2), .Mode(0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr(wr), .i_data(data), .i_rd(rd),
    .o_data(b_data), .o_valid(b_valid), .o_full(b_full), .o_empty(b_empty),
    .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_count),
    .o_overflow(b_ovf), .o_underflow(b_udf)
  );
  fifo_level #(.Width(8), .Depth(4), .AlmostFull(3), .AlmostEmpty(1), .Mode(1)) u_f (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_wr(wr), .i_data(data), .i_rd(rd),
    .o_data(f_data), .o_valid(f_valid), .o_full(f_full), .o_empty(f_empty),
    .o_almost_full(f_af), .o_almost_empty(f_ae), .o_count(f_count),
    .o_overflow(f_ovf), .o_underflow(f_udf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] d);
    wr = 1'b1;
    data = d;
    step();
    wr = 1'b0;
  endtask
  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask
  task automatic flush();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; data = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_ae", a_ae, 1);
    chk("rst_full", a_full, 0);
    chk("rst_af", a_af, 0);
    chk("rst_data", a_data, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_udf", a_udf, 0);
    chk("rst_fvalid", f_valid, 0);
    @(negedge clk) rst = 1'b0;
    // fill and drain on Depth 4 STD
    for (int i = 0; i < 4; i++) begin
      push(8'hA1 + 8'(i));
      chk("fill_count", a_count, i + 1);
    end
    chk("fill_full", a_full, 1);
    chk("fill_empty", a_empty, 0);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("drain_data", a_data, 8'hA1 + i);
      chk("drain_valid", a_valid, 1);
    end
    chk("drain_empty", a_empty, 1);
    step();
    chk("valid_pulse", a_valid, 0);
    chk("hold_data", a_data, 8'hA4);
    // overflow / underflow / flush
    flush();
    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    push(8'hB5);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_count, 4);
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("ovf_data", a_data, 8'hA1 + i);
    end
    pop();
    chk("udf_set", a_udf, 1);
    chk("udf_count", a_count, 0);
    chk("udf_novalid", a_valid, 0);
    flush();
    chk("clr_ovf", a_ovf, 0);
    chk("clr_udf", a_udf, 0);
    clr = 1'b1; wr = 1'b1; rd = 1'b1; data = 8'hEE;
    step();
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
    chk("clr_ovr_count", a_count, 0);
    chk("clr_ovr_udf", a_udf, 0);
    chk("clr_ovr_empty", a_empty, 1);
    // simultaneous at count 2 across pointer wrap
    push(8'h10);
    push(8'h11);
    for (int k = 0; k < 16; k++) begin
      wr = 1'b1; rd = 1'b1; data = 8'h12 + 8'(k);
      step();
      chk("sim_count", a_count, 2);
      chk("sim_data", a_data, 8'h10 + k);
    end
    wr = 1'b0; rd = 1'b0;
    flush();
    wr = 1'b1; rd = 1'b1; data = 8'h20;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("sim_empty_count", a_count, 1);
    chk("sim_empty_udf", a_udf, 1);
    chk("sim_empty_valid", a_valid, 0);
    push(8'h21);
    push(8'h22);
    push(8'h23);
    chk("sim_full_pre", a_count, 4);
    wr = 1'b1; rd = 1'b1; data = 8'h24;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("sim_full_count", a_count, 3);
    chk("sim_full_ovf", a_ovf, 1);
    chk("sim_full_data", a_data, 8'h20);
    // thresholds on Depth 16
    flush();
    for (int i = 1; i <= 14; i++) begin
      push(8'(i));
      if (i == 2) chk("ae_at2", b_ae, 1);
      if (i == 3) chk("ae_at3", b_ae, 0);
      if (i == 13) chk("af_at13", b_af, 0);
      if (i == 14) chk("af_at14", b_af, 1);
    end
    chk("thr_count", b_count, 14);
    pop();
    chk("drain13_count", b_count, 13);
    chk("drain13_af", b_af, 0);
    chk("drain13_data", b_data, 1);
    // FWFT
    flush();
    push(8'h55);
    chk("fwft_data1", f_data, 8'h55);
    chk("fwft_valid1", f_valid, 1);
    chk("fwft_empty1", f_empty, 0);
    push(8'h66);
    chk("fwft_head", f_data, 8'h55);
    chk("fwft_count", f_count, 2);
    pop();
    chk("fwft_data2", f_data, 8'h66);
    chk("fwft_valid2", f_valid, 1);
    pop();
    chk("fwft_valid3", f_valid, 0);
    chk("fwft_empty3", f_empty, 1);
    // async reset mid-stream
    flush();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("pre_rst_count", a_count, 3);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("arst_count", a_count, 0);
    chk("arst_empty", a_empty, 1);
    chk("arst_ae", a_ae, 1);
    chk("arst_data", a_data, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_fvalid", f_valid, 0);
    #1 rst = 1'b0;
    push(8'h77);
    chk("post_rst_count", a_count, 1);
    chk("post_rst_fwft", f_data, 8'h77);
    pop();
    chk("post_rst_data", a_data, 8'h77);
    chk("post_rst_valid", a_valid, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
